input_debounce: RTL and testbench
=================================

# input_debounce

Input-conditioning stage that sits directly upstream of the pattern-recognising Mealy FSM. It takes an asynchronous, bouncy single-bit input (pushbutton or switch), synchronises it into the `clk` domain and debounces it. It then drives a clean level, suitable for the FSM's `a` input, together with one-cycle edge pulses. A level change is accepted only after the synchronised input has held the new value for `STABLE_CYCLES` consecutive clock samples.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops; legal range ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive equal synchronised samples required to accept a change; legal range ≥ 2. Counter width is `$clog2(STABLE_CYCLES+1)`.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `raw`  input  1  asynchronous, possibly bouncing input.
- `a_clean`  output  1  debounced level (registered).
- `rise`  output  1  one-cycle pulse, coincident with the first cycle `a_clean`=1 (registered).
- `fall`  output  1  one-cycle pulse, coincident with the first cycle `a_clean`=0 (registered).
- `busy`  output  1  high while a candidate change is being qualified (state WAIT_HI or WAIT_LO).

## Operation
- Synchroniser: `raw` feeds a `SYNC_STAGES`-deep shift chain. Its last stage, `s`, is the only signal the FSM samples.
- FSM states:
  - IDLE_LO: `a_clean`=0. If `s`=1, go to WAIT_HI with cnt=1; otherwise stay, cnt=0.
  - WAIT_HI:
    - If `s`=0, go to IDLE_LO with cnt=0 (bounce rejected, no pulse).
    - Else if cnt==`STABLE_CYCLES`-1, go to IDLE_HI with cnt=0, set `a_clean`=1 and assert `rise`.
    - Else cnt++.
  - IDLE_HI and WAIT_LO: mirror images of IDLE_LO and WAIT_HI with polarity inverted; `fall` is asserted on acceptance.
- Encoding out-of-range states: the `default` branch returns to IDLE_LO with cnt=0.
- `rise` and `fall` are high for exactly one cycle per accepted edge and are never high together.
- `busy` is a registered decode, high exactly while state is WAIT_HI or WAIT_LO.
- The counter never exceeds `STABLE_CYCLES`-1 and never wraps. It is cleared on every return to an IDLE state.
- A bounce during WAIT restarts qualification from scratch; partial counts are never retained.

## Timing
- Reset values: all synchroniser flops 0, state IDLE_LO, cnt 0, `a_clean`=0, `rise`=0, `fall`=0, `busy`=0.
- Latency: number the first rising edge that captures the new `raw` value into sync stage 1 as edge 1.
  - Stable change: `a_clean` and the edge pulse update on edge `SYNC_STAGES`+`STABLE_CYCLES`. With the defaults this is edge 6.
  - `busy` rises on edge `SYNC_STAGES`+1 and falls together with the `a_clean` update.
- Minimum accepted pulse width on `raw` is `STABLE_CYCLES` clock periods. Shorter pulses produce no output activity other than `busy`.
- Reset asserted mid-WAIT: aborts immediately (asynchronously), with no pulse. After release the block restarts from IDLE_LO.
- `raw`=1 held through reset: after release, `a_clean` rises and `rise` pulses at the normal latency, counting from the first post-reset edge.
- `s` toggling every cycle: the block alternates between IDLE and WAIT and `a_clean` never changes.

## Structure
- Package `input_debounce_pkg` holds `typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;`.
- Sub-module `sync_chain` holds the parameterised `SYNC_STAGES` flop chain with asynchronous reset to 0. It is instantiated once; FSM, counter and output registers live in `input_debounce`.

## Test plan
All scenarios use the defaults (`SYNC_STAGES`=2, `STABLE_CYCLES`=4).
- Reset: hold `reset`=1 while `raw` toggles → all outputs 0, state IDLE_LO. Release with `raw`=0 → outputs stay 0.
- Clean press: `raw` 0→1 and held → `a_clean`=1 and `rise`=1 on edge 6 only. `busy`=1 on edges 3–5. Later `raw` 1→0 held → `fall`=1 on edge 6 after capture, `a_clean`=0.
- Bounce rejection: `raw` pattern 1,1,0,1,1,1,1 per cycle → no change until 4 consecutive 1s reach `s`. `rise` occurs exactly once, on edge 2+4 counted from the last 0→1 capture.
- Glitch: `raw`=1 for 3 cycles, then 0 → `a_clean` stays 0, `rise` never asserts, `busy` pulses high for 3 cycles.
- Reset mid-qualification: assert `reset` asynchronously while `busy`=1 → `busy`, `rise` and `a_clean` are 0 immediately. After release, with `raw` held 1 → `rise` on edge 6 after release.
- Downstream integration: connect `a_clean` to the Mealy FSM's `a`. Drive press, release, press (each ≥ 8 cycles) → the FSM's `y` asserts exactly on the cycles where `a_clean`=1 and the FSM state is S1.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared types for the input debouncer: the qualification FSM state encoding.
package input_debounce_pkg;

   typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous bit into the clk domain.
// Latency STAGES cycles; no flow control, samples every cycle.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], din};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronises and debounces a bouncy input into a clean level plus rise/fall pulses.
// Latency SYNC_STAGES+STABLE_CYCLES edges from raw capture to a_clean; no backpressure.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic a_clean,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int            CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic            s;
   db_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            a_clean_q, a_clean_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic            busy_q, busy_d;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (reset),
      .din  (raw),
      .dout (s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE_LO;
         cnt_q     <= '0;
         a_clean_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_clean_q <= a_clean_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         busy_q    <= busy_d;
      end
   end

   // Any sample disagreeing with the candidate level drops straight back to IDLE,
   // so a bounce always restarts qualification from a count of one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE_LO: begin
            if (s) begin
               state_d = WAIT_HI;
               cnt_d   = CW'(1);
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_HI: begin
            if (!s) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_d = WAIT_LO;
               cnt_d   = CW'(1);
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode the next state so they register on the same edge as the transition.
   always_comb begin
      a_clean_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
      rise_d    = (state_q == WAIT_HI) && (state_d == IDLE_HI);
      fall_d    = (state_q == WAIT_LO) && (state_d == IDLE_LO);
      busy_d    = (state_d == WAIT_HI) || (state_d == WAIT_LO);
   end

   assign a_clean = a_clean_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: vector table, corner sequences, random vs run-length model.
module tb_input_debounce;

   localparam int SYNC = 2;
   localparam int STAB = 4;

   logic clk = 1'b0;
   logic reset;
   logic raw;
   logic a_clean, rise, fall, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_debounce #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STAB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw),
      .a_clean (a_clean),
      .rise    (rise),
      .fall    (fall),
      .busy    (busy)
   );

   // Reference: raw is seen SYNC edges later; level flips after STAB consecutive disagreeing samples.
   bit m_hist[$];
   bit m_level;
   int m_run;
   bit m_rise, m_fall, m_busy;

   task automatic model_reset();
      m_hist = {};
      repeat (SYNC) m_hist.push_back(1'b0);
      m_level = 1'b0;
      m_run   = 0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_busy  = 1'b0;
   endtask

   task automatic model_edge(input bit r);
      bit s;
      s = m_hist.pop_front();
      m_hist.push_back(r);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_level) begin
         m_run++;
         if (m_run == STAB) begin
            m_level = s;
            m_rise  = s;
            m_fall  = !s;
            m_run   = 0;
         end
      end else begin
         m_run = 0;
      end
      m_busy = (m_run != 0);
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r);
      raw = r;
      @(posedge clk);
      if (!reset) model_edge(r);
      #1;
   endtask

   task automatic check_outs(input string tag, input bit a, input bit r, input bit f, input bit b);
      check({tag, "_a_clean"}, a_clean, a);
      check({tag, "_rise"}, rise, r);
      check({tag, "_fall"}, fall, f);
      check({tag, "_busy"}, busy, b);
   endtask

   typedef struct {
      bit raw;
      bit a;
      bit r;
      bit f;
      bit b;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r_in, input bit a, input bit r, input bit f, input bit b);
      vec_t v;
      v.raw = r_in; v.a = a; v.r = r; v.f = f; v.b = b;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      int  bcount;
      bit  saw;
      bit  found;

      // Clean press then release (edges counted from raw capture).
      add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,0,0,1); add(1,0,0,0,1);
      add(1,0,0,0,1); add(1,1,1,0,0); add(1,1,0,0,0); add(1,1,0,0,0);
      add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,1); add(0,1,0,0,1);
      add(0,1,0,0,1); add(0,0,0,1,0); add(0,0,0,0,0); add(0,0,0,0,0);
      // Bounce 1,1,0,1,1,1,1...: rise six edges after the last 0->1 capture.
      add(1,0,0,0,0); add(1,0,0,0,0); add(0,0,0,0,1); add(1,0,0,0,1);
      add(1,0,0,0,0); add(1,0,0,0,1); add(1,0,0,0,1); add(1,0,0,0,1);
      add(1,1,1,0,0); add(1,1,0,0,0);
      add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,1); add(0,1,0,0,1);
      add(0,1,0,0,1); add(0,0,0,1,0); add(0,0,0,0,0); add(0,0,0,0,0);

      reset = 1'b1;
      raw   = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'($urandom_range(0, 1)));
         check_outs("in_reset", 0, 0, 0, 0);
      end
      raw = 1'b0;
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         check_outs("post_reset", 0, 0, 0, 0);
      end

      foreach (tbl[i]) begin
         step(tbl[i].raw);
         check_outs($sformatf("vec%0d", i), tbl[i].a, tbl[i].r, tbl[i].f, tbl[i].b);
      end

      // Glitch of three cycles: only busy moves.
      bcount = 0;
      saw    = 1'b0;
      for (int i = 0; i < 11; i++) begin
         step(i < 3);
         if (busy) bcount++;
         if (rise || a_clean) saw = 1'b1;
      end
      check_int("glitch_busy_cycles", bcount, 3);
      check("glitch_no_output", saw, 1'b0);

      // Reset asserted while qualifying a press, raw held high across it.
      for (int i = 0; i < 3; i++) step(1'b1);
      check("midq_busy_before", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_outs("midq_async", 0, 0, 0, 0);
      model_reset();
      step(1'b1);
      step(1'b1);
      #2 reset = 1'b0;
      found = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step(1'b1);
         if (rise && !found) begin
            found = 1'b1;
            check_int("midq_rise_edge", e, SYNC + STAB);
         end
      end
      check("midq_rise_seen", found, 1'b1);
      check("midq_a_clean", a_clean, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0);
      check("settle_low", a_clean, 1'b0);

      // Random bursts of varying length against the model.
      for (int k = 0; k < 300; k++) begin
         bit v;
         int len;
         v   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) begin
            step(v);
            check_outs("rand", m_level, m_rise, m_fall, m_busy);
            check("rand_rise_fall_excl", rise & fall, 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
